// File: rtl/nn_pkg.sv
// Shared constants and types for the layer output collector.
package nn_pkg;

  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 8;
  localparam int DEF_N_OUT = 8;

  // Signed activation limits for the default output width.
  localparam logic signed [DEF_OUT_W-1:0] SAT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam logic signed [DEF_OUT_W-1:0] SAT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } coll_state_e;

endpackage

// File: rtl/layer_output_collector_if.sv
// Handshake/bus bundle between the collector, its MAC source and its consumer.
interface layer_output_collector_if #(
  parameter int ACC_W = nn_pkg::DEF_ACC_W,
  parameter int OUT_W = nn_pkg::DEF_OUT_W,
  parameter int N_OUT = nn_pkg::DEF_N_OUT
);
  localparam int IDX_W = (N_OUT > 2) ? $clog2(N_OUT) : 1;

  logic             start;
  logic             relu_en;
  logic             in_valid;
  logic [ACC_W-1:0] in_acc0;
  logic [ACC_W-1:0] in_acc1;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             layer_done;
  logic             busy;
  logic             sat_flag;
  logic             drop_err;

  modport master (
    output start, relu_en, in_valid, in_acc0, in_acc1, out_ready,
    input  out_valid, out_data, out_idx, layer_done, busy, sat_flag, drop_err
  );

  modport slave (
    input  start, relu_en, in_valid, in_acc0, in_acc1, out_ready,
    output out_valid, out_data, out_idx, layer_done, busy, sat_flag, drop_err
  );
endinterface

// File: rtl/requant_sat_relu.sv
// Requantises one accumulator: arithmetic shift, signed clamp to OUT_W, optional ReLU.
module requant_sat_relu #(
  parameter int ACC_W = nn_pkg::DEF_ACC_W,
  parameter int OUT_W = nn_pkg::DEF_OUT_W,
  parameter int SHIFT = nn_pkg::DEF_SHIFT
) (
  input  logic [ACC_W-1:0] acc,
  input  logic             relu,
  output logic [OUT_W-1:0] y,
  output logic             sat
);
  localparam logic signed [ACC_W-1:0] HI_LIMIT = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] LO_LIMIT = ~HI_LIMIT;

  logic signed [ACC_W-1:0] shifted_s;
  logic        [OUT_W-1:0] clip_s;

  // Shift, clamp, then ReLU; a clamped negative still reports saturation.
  always_comb begin
    shifted_s = $signed(acc) >>> SHIFT;
    sat       = 1'b0;
    clip_s    = shifted_s[OUT_W-1:0];
    if (shifted_s > HI_LIMIT) begin
      clip_s = HI_LIMIT[OUT_W-1:0];
      sat    = 1'b1;
    end else if (shifted_s < LO_LIMIT) begin
      clip_s = LO_LIMIT[OUT_W-1:0];
      sat    = 1'b1;
    end else begin
      clip_s = shifted_s[OUT_W-1:0];
      sat    = 1'b0;
    end
    if (relu && clip_s[OUT_W-1]) begin
      y = {OUT_W{1'b0}};
    end else begin
      y = clip_s;
    end
  end
endmodule

// File: rtl/layer_output_collector.sv
// Captures one layer of requantised MAC results two at a time, then drains
// them in index order over a valid/ready stream.
module layer_output_collector
  import nn_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int N_OUT = DEF_N_OUT
) (
  input  logic                     clk,
  input  logic                     rst,
  layer_output_collector_if.slave  bus
);
  localparam int IDX_W = (N_OUT > 2) ? $clog2(N_OUT) : 1;

  coll_state_e      state_r, next_state_s;
  logic [IDX_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [OUT_W-1:0] buf_r [N_OUT];
  logic [OUT_W-1:0] out_data_r;
  logic             relu_r, out_valid_r, layer_done_r, busy_r, sat_flag_r, drop_err_r;
  logic [OUT_W-1:0] y0_s, y1_s;
  logic             sat0_s, sat1_s;
  logic             start_acc_s, wr_en_s, last_wr_s, rd_en_s, last_rd_s, drop_s;

  requant_sat_relu #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane0 (
    .acc(bus.in_acc0), .relu(relu_r), .y(y0_s), .sat(sat0_s)
  );
  requant_sat_relu #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane1 (
    .acc(bus.in_acc1), .relu(relu_r), .y(y1_s), .sat(sat1_s)
  );

  assign start_acc_s = bus.start && (state_r == IDLE);
  assign wr_en_s     = bus.in_valid && (state_r == COLLECT);
  assign drop_s      = bus.in_valid && (state_r != COLLECT);
  assign last_wr_s   = wr_en_s && (wr_ptr_r == IDX_W'(N_OUT-2));
  assign rd_en_s     = out_valid_r && bus.out_ready;
  assign last_rd_s   = rd_en_s && (rd_ptr_r == IDX_W'(N_OUT-1));

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (bus.start) next_state_s = COLLECT; else next_state_s = IDLE;
      COLLECT: if (last_wr_s) next_state_s = DRAIN;   else next_state_s = COLLECT;
      DRAIN:   if (last_rd_s) next_state_s = IDLE;    else next_state_s = DRAIN;
      default: next_state_s = IDLE;
    endcase
  end

  // Activation buffer: unreset storage, written only while collecting.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_r[wr_ptr_r]               <= y0_s;
      buf_r[wr_ptr_r + IDX_W'(1)]   <= y1_s;
    end
  end

  // State, pointers, sticky flags and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {IDX_W{1'b0}};
      rd_ptr_r     <= {IDX_W{1'b0}};
      relu_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {OUT_W{1'b0}};
      layer_done_r <= 1'b0;
      busy_r       <= 1'b0;
      sat_flag_r   <= 1'b0;
      drop_err_r   <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      busy_r       <= (next_state_s != IDLE);
      out_valid_r  <= (next_state_s == DRAIN);
      layer_done_r <= last_wr_s;
      if (start_acc_s) begin
        wr_ptr_r <= {IDX_W{1'b0}};
        rd_ptr_r <= {IDX_W{1'b0}};
        relu_r   <= bus.relu_en;
      end else begin
        if (wr_en_s && !last_wr_s) wr_ptr_r <= wr_ptr_r + IDX_W'(2);
        if (last_rd_s)             rd_ptr_r <= {IDX_W{1'b0}};
        else if (rd_en_s)          rd_ptr_r <= rd_ptr_r + IDX_W'(1);
      end
      // Output data is preloaded so it is already valid on the first DRAIN cycle.
      if (last_wr_s) begin
        out_data_r <= (N_OUT == 2) ? y0_s : buf_r[0];
      end else if (last_rd_s) begin
        out_data_r <= {OUT_W{1'b0}};
      end else if (rd_en_s) begin
        out_data_r <= buf_r[rd_ptr_r + IDX_W'(1)];
      end
      sat_flag_r <= (start_acc_s ? 1'b0 : sat_flag_r) | (wr_en_s && (sat0_s || sat1_s));
      drop_err_r <= (start_acc_s ? 1'b0 : drop_err_r) | drop_s;
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_idx    = rd_ptr_r;
  assign bus.layer_done = layer_done_r;
  assign bus.busy       = busy_r;
  assign bus.sat_flag   = sat_flag_r;
  assign bus.drop_err   = drop_err_r;
endmodule

// File: tb/tb_layer_output_collector.sv
// Randomised self-checking bench for layer_output_collector against a behavioural model.
module tb_layer_output_collector;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 8;
  localparam int N_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_output_collector_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .N_OUT(N_OUT)) bus ();

  layer_output_collector #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [ACC_W-1:0] stim [N_OUT];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Floor division by 2^SHIFT, clamp to the signed OUT_W range, then ReLU.
  task automatic ref_conv(input logic [ACC_W-1:0] x, input bit relu,
                          output logic [OUT_W-1:0] y, output bit sat);
    longint xi, s, div, hi, lo;
    xi  = longint'($signed(x));
    div = longint'(1) << SHIFT;
    hi  = (longint'(1) << (OUT_W-1)) - 1;
    lo  = -(longint'(1) << (OUT_W-1));
    if (xi >= 0) s = xi / div;
    else         s = -((-xi + div - 1) / div);
    sat = 1'b0;
    if (s > hi) begin s = hi; sat = 1'b1; end
    else if (s < lo) begin s = lo; sat = 1'b1; end
    if (relu && s < 0) s = 0;
    y = OUT_W'(s);
  endtask

  function automatic logic [ACC_W-1:0] rand_acc();
    logic [ACC_W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = ACC_W'($signed($urandom_range(0, 2097151)) - 1048576);
      2: v = ($urandom_range(0, 1) == 1) ? ACC_W'(32'h007FFF00 + $urandom_range(0, 511) - 256)
                                          : ACC_W'(32'hFF800000 + $urandom_range(0, 511) - 256);
      default: v = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF : 32'h80000000;
    endcase
    return v;
  endfunction

  task automatic run_layer(input bit relu, input int ready_mode, input bit start_with_valid,
                           input bit start_in_collect, input bit inject_drop);
    logic [OUT_W-1:0] exp_q [$];
    logic [OUT_W-1:0] yv;
    logic [6:0] pat;
    bit s0, sat_any, exp_drop, r;
    int idx, cyc;
    pat     = 7'b1101001;
    sat_any = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      ref_conv(stim[i], relu, yv, s0);
      exp_q.push_back(yv);
      sat_any |= s0;
    end
    @(negedge clk);
    bus.start     = 1'b1;
    bus.relu_en   = relu;
    bus.in_valid  = start_with_valid;
    bus.in_acc0   = rand_acc();
    bus.in_acc1   = rand_acc();
    bus.out_ready = 1'b0;
    exp_drop      = start_with_valid;
    @(negedge clk);
    check_val("busy_rise", bus.busy, 1);
    check_val("drop_after_start", bus.drop_err, exp_drop);
    check_val("sat_after_start", bus.sat_flag, 0);
    check_val("valid_in_collect", bus.out_valid, 0);
    bus.start   = start_in_collect;
    bus.relu_en = ~relu;
    for (int k = 0; k < N_OUT/2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_acc0  = stim[2*k];
      bus.in_acc1  = stim[2*k+1];
      @(negedge clk);
      bus.start = 1'b0;
      if (k < N_OUT/2 - 1) check_val("done_early", bus.layer_done, 0);
    end
    bus.in_valid = 1'b0;
    check_val("layer_done", bus.layer_done, 1);
    check_val("sat_flag", bus.sat_flag, sat_any);
    idx = 0;
    cyc = 0;
    while (idx < N_OUT && cyc < 200) begin
      if (cyc == 1) check_val("done_pulse_width", bus.layer_done, 0);
      check_val("out_valid", bus.out_valid, 1);
      check_val("out_idx", bus.out_idx, idx);
      check_val("out_data", bus.out_data, exp_q[idx]);
      check_val("drop_err", bus.drop_err, exp_drop);
      check_val("sat_hold", bus.sat_flag, sat_any);
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (cyc < 7) ? pat[cyc] : 1'b1;
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      bus.out_ready = r;
      if (inject_drop && cyc == 0) begin
        bus.in_valid = 1'b1;
        bus.in_acc0  = rand_acc();
        bus.in_acc1  = rand_acc();
        exp_drop     = 1'b1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (r) idx++;
      cyc++;
    end
    check_val("drain_count", idx, N_OUT);
    bus.out_ready = 1'b0;
    check_val("valid_after_drain", bus.out_valid, 0);
    check_val("busy_after_drain", bus.busy, 0);
    check_val("data_after_drain", bus.out_data, 0);
    check_val("idx_after_drain", bus.out_idx, 0);
    check_val("drop_after_drain", bus.drop_err, exp_drop);
    check_val("sat_after_drain", bus.sat_flag, sat_any);
  endtask

  task automatic reset_mid_collect();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.relu_en = 1'b0;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_acc0  = 32'h7FFFFFFF;
    bus.in_acc1  = 32'h00000100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_valid", bus.out_valid, 0);
    check_val("rst_done", bus.layer_done, 0);
    check_val("rst_sat", bus.sat_flag, 0);
    check_val("rst_idx", bus.out_idx, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("rst_no_done", bus.layer_done, 0);
      check_val("rst_idle_busy", bus.busy, 0);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.relu_en   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_acc0   = '0;
    bus.in_acc1   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_busy", bus.busy, 0);
    check_val("reset_valid", bus.out_valid, 0);
    check_val("reset_done", bus.layer_done, 0);
    check_val("reset_sat", bus.sat_flag, 0);
    check_val("reset_drop", bus.drop_err, 0);
    check_val("reset_data", bus.out_data, 0);
    check_val("reset_idx", bus.out_idx, 0);
    rst = 1'b0;

    stim = '{32'h00000300, 32'h00000500, 32'h00000100, 32'hFFFFFF00};
    run_layer(1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_layer(1'b1, 0, 1'b0, 1'b0, 1'b0);
    stim = '{32'h7FFFFFFF, 32'h80000000, 32'h00001000, 32'hFFFF0000};
    run_layer(1'b0, 1, 1'b0, 1'b0, 1'b0);
    run_layer(1'b1, 1, 1'b0, 1'b0, 1'b0);
    stim = '{32'h00012345, 32'hFFF00000, 32'h00000080, 32'hFFFFFF7F};
    run_layer(1'b0, 1, 1'b0, 1'b1, 1'b1);
    run_layer(1'b0, 0, 1'b1, 1'b0, 1'b0);
    run_layer(1'b1, 0, 1'b0, 1'b0, 1'b0);
    reset_mid_collect();
    stim = '{32'h00000A00, 32'hFFFFF600, 32'h00FFFFFF, 32'hFF000000};
    run_layer(1'b0, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < N_OUT; i++) stim[i] = rand_acc();
      run_layer(bit'($urandom_range(0, 1)), 2, bit'($urandom_range(0, 3) == 0),
                bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/layer_output_collector.md
Name: layer_output_collector

Overview:
- Sits directly downstream of the layer-phase controller (layering_pipeline_ctrl_nn).
- Consumes MAC accumulator results, two per cycle, that the controller gates out over its two-cycle layer phase (tile1 pair, then tile2 pair).
- Applies per-layer arithmetic right shift, signed saturation and optional ReLU, then buffers one full layer of N_OUT activations.
- Drains the buffer as a valid/ready stream for the next layer's input loader, and pulses layer_done when a layer is fully captured.

Parameters:
- ACC_W, 32: accumulator width of incoming MAC results (signed).
- OUT_W, 16: activation width after requantisation (signed).
- SHIFT, 8: arithmetic right-shift amount (fixed-point fraction bits); legal range 0..ACC_W-1.
- N_OUT, 8: activations per layer; must be even and >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin collecting a layer; honoured in IDLE only
- relu_en  in  1  ReLU enable; sampled on accepted start
- in_valid  in  1  in_acc0/in_acc1 carry a result pair this cycle
- in_acc0  in  ACC_W  result for even index y[2k]
- in_acc1  in  ACC_W  result for odd index y[2k+1]
- out_valid  out  1  out_data holds a buffered activation
- out_ready  in  1  downstream accepts out_data
- out_data  out  OUT_W  activation value; 0 when out_valid=0
- out_idx  out  $clog2(N_OUT)  index of out_data within the layer
- layer_done  out  1  one-cycle pulse: layer fully captured
- busy  out  1  registered, high when state != IDLE
- sat_flag  out  1  sticky: any saturation occurred this layer
- drop_err  out  1  sticky: in_valid arrived outside COLLECT

Behaviour:
- Reset: state=IDLE; wr_ptr=rd_ptr=0. Outputs busy, out_valid, layer_done, sat_flag and drop_err are all 0; out_data=0, out_idx=0. Buffer contents are not reset.
- State IDLE:
  - start -> COLLECT.
  - On that edge: clear wr_ptr, rd_ptr, sat_flag and drop_err; latch relu_en.
- State COLLECT:
  - in_valid writes conv(in_acc0) to buf[wr_ptr] and conv(in_acc1) to buf[wr_ptr+1] at the same edge, then wr_ptr += 2.
  - Capture latency is 1 edge.
  - When the write fills buf[N_OUT-1]: transition to DRAIN on that edge; layer_done=1 for exactly the following cycle.
- State DRAIN:
  - out_valid=1, out_data=buf[rd_ptr], out_idx=rd_ptr.
  - When out_valid & out_ready: rd_ptr++.
  - Accepting index N_OUT-1 -> IDLE, with out_valid low the next cycle.
  - Data is held stable while out_ready=0.
- conv(x), applied in this order:
  1. s = x >>> SHIFT (sign-preserving).
  2. If s > 2^(OUT_W-1)-1, result = 0x7FF..F; if s < -2^(OUT_W-1), result = 0x800..0; sat_flag set in either case.
  3. If relu_en is latched and the result is negative, result = 0.
- sat_flag: set only on the edge the saturating pair is written; ReLU on an already-saturated negative value still sets sat_flag.
- Boundaries and simultaneous events:
  - in_valid in IDLE or DRAIN: pair dropped, buffer unchanged, drop_err=1 (sticky until next accepted start).
  - start outside IDLE: ignored, no error.
  - start and in_valid in the same IDLE cycle: start honoured, pair dropped, drop_err set after the clear (ends at 1).
  - wr_ptr and rd_ptr never wrap within a layer; both are reset by start.
- busy: registered as (next_state != IDLE), so it rises on the edge after start.
- Reset mid-operation: immediate return to reset values; partial layer discarded, no layer_done.
- Throughput: back-to-back in_valid every cycle supported; a layer collects in N_OUT/2 cycles minimum.

Decomposition:
- Shared package (nn_pkg):
  - collector state encoding: IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2.
  - default ACC_W/OUT_W/SHIFT constants.
  - saturation limit constants derived from OUT_W.
- One combinational sub-module, requant_sat_relu (shift, saturate, ReLU, sat output), instantiated twice for the even/odd lanes.
- Buffer and FSM stay in the top module.

Test Plan (ACC_W=32, OUT_W=16, SHIFT=8, N_OUT=4):
- Basic capture, relu_en=0:
  - Stimulus: start, then pairs (0x00000300, 0x00000500) and (0x00000100, 0xFFFFFF00) on consecutive cycles, out_ready=1.
  - Required: layer_done pulses the cycle after the 2nd pair; drain yields idx0..3 = 0x0003, 0x0005, 0x0001, 0xFFFF; busy returns to 0.
- ReLU: same stimulus with relu_en=1 at start -> 0x0003, 0x0005, 0x0001, 0x0000; sat_flag=0.
- Saturation:
  - Stimulus: pair (0x7FFFFFFF, 0x80000000).
  - Required: 0x7FFF, 0x8000; sat_flag=1 and held through DRAIN; cleared by next start.
- Backpressure: out_ready pattern 1,0,0,1,0,1,1 -> each out_data/out_idx held while stalled, order 0..3 preserved, no duplicates or losses.
- Protocol errors:
  - in_valid during DRAIN -> buffer unchanged, drop_err=1.
  - start during COLLECT -> ignored, capture continues.
  - Next IDLE start clears drop_err to 0.
- Reset mid-COLLECT:
  - Stimulus: assert rst after one pair.
  - Required: busy=0, out_valid=0, layer_done never pulses; a fresh start then captures a full new layer correctly from idx 0.
